// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - two-stage shift/rotate unit with valid/ready handshake
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module shift_stage #(
    parameter int n = `DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [n-1:0]         in_a,
    input  logic [$clog2(n)-1:0] in_b,
    input  logic [2:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [n-1:0]         out_result,
    output logic                 out_carry,
    output logic                 out_zero,
    output logic                 out_neg,
    output logic                 out_err
);
    localparam int LW = $clog2(n);

    logic          s1_valid_q, s1_valid_d;
    logic [n-1:0]  s1_a_q;
    logic [LW-1:0] s1_b_q;
    logic          s1_left_q, s1_rot_q, s1_fill_q, s1_err_q;
    logic          out_valid_q, out_valid_d;
    logic [n-1:0]  res_q, res_d;
    logic          carry_q, carry_d, zero_q, neg_q, err_q;
    logic          s2_load;
    logic          dec_left, dec_rot, dec_fill, dec_err;

    assign s2_load    = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_load;
    assign s1_valid_d = in_ready ? in_valid : s1_valid_q;
    assign out_valid_d = s2_load ? s1_valid_q : out_valid_q;

    always_comb begin
        dec_left = 1'b0;
        dec_rot  = 1'b0;
        dec_fill = 1'b0;
        dec_err  = 1'b0;
        case (in_op)
            3'd0: dec_left = 1'b1;
            3'd1: ;
            3'd2: dec_fill = in_a[n-1];
            3'd3: begin dec_left = 1'b1; dec_rot = 1'b1; end
            3'd4: dec_rot = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_left_q  <= 1'b0;
            s1_rot_q   <= 1'b0;
            s1_fill_q  <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_ready && in_valid) begin
                s1_a_q    <= in_a;
                s1_b_q    <= in_b;
                s1_left_q <= dec_left;
                s1_rot_q  <= dec_rot;
                s1_fill_q <= dec_fill;
                s1_err_q  <= dec_err;
            end
        end
    end

    // Barrel shifter: level i moves by 2**i when b[i] is set.
    logic [n-1:0] lvl [LW+1];
    assign lvl[0] = s1_a_q;

    for (genvar i = 0; i < LW; i++) begin : g_lvl
        localparam int S = 1 << i;
        logic [n-1:0] shl, shr;
        assign shl = {lvl[i][n-1-S:0], s1_rot_q ? lvl[i][n-1 -: S] : {S{s1_fill_q}}};
        assign shr = {s1_rot_q ? lvl[i][S-1:0] : {S{s1_fill_q}}, lvl[i][n-1:S]};
        assign lvl[i+1] = !s1_b_q[i] ? lvl[i] : (s1_left_q ? shl : shr);
    end

    logic [LW-1:0] idx_l, idx_r;
    logic [n-1:0]  shifted;
    assign idx_l   = '0 - s1_b_q;
    assign idx_r   = s1_b_q - LW'(1);
    assign shifted = lvl[LW];

    always_comb begin
        res_d   = s1_err_q ? s1_a_q : shifted;
        carry_d = 1'b0;
        if (!s1_err_q && s1_b_q != '0) begin
            case ({s1_left_q, s1_rot_q})
                2'b10:   carry_d = s1_a_q[idx_l];
                2'b00:   carry_d = s1_a_q[idx_r];
                2'b11:   carry_d = shifted[0];
                default: carry_d = shifted[n-1];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s2_load && s1_valid_q) begin
                res_q   <= res_d;
                carry_q <= carry_d;
                zero_q  <= (res_d == '0);
                neg_q   <= res_d[n-1];
                err_q   <= s1_err_q;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign out_carry  = carry_q;
    assign out_zero   = zero_q;
    assign out_neg    = neg_q;
    assign out_err    = err_q;
endmodule

// File: tb/tb_shift_stage.sv
// tb/tb_shift_stage.sv - scoreboard bench for shift_stage (n=8)
module tb_shift_stage;
    localparam int N = 8;

    logic         clk, rst_n;
    logic         in_valid, in_ready;
    logic [N-1:0] in_a;
    logic [2:0]   in_b;
    logic [2:0]   in_op;
    logic         out_valid, out_ready;
    logic [N-1:0] out_result;
    logic         out_carry, out_zero, out_neg, out_err;

    shift_stage #(.n(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry),
        .out_zero(out_zero), .out_neg(out_neg), .out_err(out_err)
    );

    typedef struct {
        logic [N-1:0] res;
        logic c, z, ng, e;
        int acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_out = 0;
    bit lat_chk = 0;
    bit rand_bp = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [2:0] b, input logic [2:0] op);
        exp_t m;
        int bi;
        bi = int'(b);
        m.res = a; m.c = 1'b0; m.e = 1'b0; m.acc = 0;
        case (op)
            3'd0: begin m.res = a << bi; if (bi != 0) m.c = a[N-bi]; end
            3'd1: begin m.res = a >> bi; if (bi != 0) m.c = a[bi-1]; end
            3'd2: begin m.res = $signed(a) >>> bi; if (bi != 0) m.c = a[bi-1]; end
            3'd3: begin m.res = (a << bi) | (a >> (N-bi)); if (bi != 0) m.c = m.res[0]; end
            3'd4: begin m.res = (a >> bi) | (a << (N-bi)); if (bi != 0) m.c = m.res[N-1]; end
            default: m.e = 1'b1;
        endcase
        m.z  = (m.res == '0);
        m.ng = m.res[N-1];
        return m;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("result", 32'(out_result), 32'(mon_e.res));
                check("carry", 32'(out_carry), 32'(mon_e.c));
                check("zero", 32'(out_zero), 32'(mon_e.z));
                check("neg", 32'(out_neg), 32'(mon_e.ng));
                check("err", 32'(out_err), 32'(mon_e.e));
                if (lat_chk) check("latency", 32'(cyc - mon_e.acc), 2);
            end
        end
        if (rst_n && in_valid && in_ready) begin
            mon_e = model(in_a, in_b, in_op);
            mon_e.acc = cyc;
            sb.push_back(mon_e);
        end
    end

    task automatic finish_send();
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            k++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [N-1:0] a, input logic [2:0] b, input logic [2:0] op);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        finish_send();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 32'(sb.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int nb;
        clk = 0; rst_n = 0; in_valid = 0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1;
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_result", 32'(out_result), 0);
        check("rst_flags", 32'({out_carry, out_zero, out_neg, out_err}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        lat_chk = 1;
        send(8'b10000111, 3'd1, 3'd0);
        send(8'b10000111, 3'd3, 3'd1);
        send(8'b10000111, 3'd3, 3'd2);
        send(8'b10000111, 3'd4, 3'd3);
        send(8'b10000111, 3'd1, 3'd4);
        drain();
        lat_chk = 0;

        send(8'b10000000, 3'd1, 3'd0);
        for (int op = 0; op < 5; op++) send(8'b10110001, 3'd0, 3'(op));
        send(8'h00, 3'd2, 3'd6);
        drain();

        out_ready = 0;
        send(8'hC3, 3'd2, 3'd3);
        send(8'h96, 3'd5, 3'd2);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        in_a = 8'h3C; in_b = 3'd7; in_op = 3'd4; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_hold", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_hold_res", 32'(out_result), 32'(sb[0].res));
            check("bp_hold_carry", 32'(out_carry), 32'(sb[0].c));
        end
        @(posedge clk); #1;
        out_ready = 1;
        finish_send();
        drain();

        rand_bp = 1;
        repeat (40) send(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        rand_bp = 0;
        out_ready = 1;
        drain();

        out_ready = 0;
        send(8'hA5, 3'd1, 3'd0);
        send(8'h5A, 3'd2, 3'd1);
        #2 rst_n = 0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_result", 32'(out_result), 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1;
        out_ready = 1;
        nb = n_out;
        repeat (4) @(negedge clk);
        check("no_stale", 32'(n_out), 32'(nb));
        @(posedge clk); #1;
        send(8'h81, 3'd7, 3'd3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
